// File: rtl/ap_ctrl_hs_driver.sv
// Initiator side of the ap_ctrl_hs block-level handshake: launches NUM_TRANS starts,
// drains the dones, and raises finish. Optional protocol checker: AP_CTRL_PROTOCOL_CHECK_EN.
module ap_ctrl_hs_driver #(
    parameter int unsigned NUM_TRANS = 16,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             hold_continue,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic             ap_continue,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] run_cycles,
    output logic             finish,
    output logic             timeout_err,
    output logic             protocol_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN, FINISH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] idle_timer;
    logic             in_run;
    logic             run_begin;
    logic             start_hs;
    logic             done_acc;
    logic             done_hs;
    logic             last_start;
    logic             all_done;
    logic             timed_out;

    // Handshake decode and transition conditions
    always_comb begin
        in_run     = (state == LAUNCH) || (state == DRAIN);
        run_begin  = (state == IDLE) && enable;
        start_hs   = ap_start && ap_ready;
        done_acc   = ap_done && ap_continue;
        done_hs    = done_acc && in_run;
        last_start = start_hs && (start_count == CNT_W'(NUM_TRANS - 1));
        all_done   = (done_count == CNT_W'(NUM_TRANS)) && ap_idle;
        timed_out  = !done_hs && (idle_timer == TMR_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)                 state_nxt = LAUNCH;
            LAUNCH:  if (last_start)             state_nxt = DRAIN;
            DRAIN:   if (all_done || timed_out)  state_nxt = FINISH;
            FINISH:  if (!enable)                state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // ap_start/finish decode straight from the state register; ap_continue is combinational
    always_comb begin
        ap_start    = (state == LAUNCH);
        finish      = (state == FINISH);
        ap_continue = (state != IDLE) && !hold_continue;
    end

    // Run counters saturate and hold their value until the next run begins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_count <= '0;
            done_count  <= '0;
            run_cycles  <= '0;
            timeout_err <= 1'b0;
        end else if (run_begin) begin
            start_count <= '0;
            done_count  <= '0;
            run_cycles  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (start_hs && (start_count != '1)) start_count <= start_count + CNT_W'(1);
            if (done_hs && (done_count != '1))   done_count  <= done_count + CNT_W'(1);
            if (in_run && (run_cycles != '1))    run_cycles  <= run_cycles + CNT_W'(1);
            if ((state == DRAIN) && !all_done && timed_out) timeout_err <= 1'b1;
        end
    end

    // Cycles since DRAIN entry or the last accepted done
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                               idle_timer <= '0;
        else if ((state != DRAIN) || done_hs)    idle_timer <= '0;
        else                                     idle_timer <= idle_timer + TMR_W'(1);
    end

`ifdef AP_CTRL_PROTOCOL_CHECK_EN
    logic viol_orphan_done;
    logic viol_ready;
    logic viol_idle_done;

    always_comb begin
        viol_orphan_done = done_acc && (done_count == start_count);
        viol_ready       = ap_ready && !ap_start;
        viol_idle_done   = ap_done && (state == IDLE);
    end

    // A violation on the run-begin edge wins over the clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                             protocol_err <= 1'b0;
        else if (viol_orphan_done || viol_ready || viol_idle_done) protocol_err <= 1'b1;
        else if (run_begin)                                    protocol_err <= 1'b0;
    end

`ifndef SYNTHESIS
    longint unsigned cycle_num;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_num <= 64'd0;
        end else begin
            cycle_num <= cycle_num + 64'd1;
            if (viol_orphan_done) $error("ap_ctrl_hs: done with nothing outstanding at cycle %0d", cycle_num);
            if (viol_ready)       $error("ap_ctrl_hs: ap_ready without ap_start at cycle %0d", cycle_num);
            if (viol_idle_done)   $error("ap_ctrl_hs: ap_done while idle at cycle %0d", cycle_num);
        end
    end
`endif
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: doc/ap_ctrl_hs_driver.md
Name: ap_ctrl_hs_driver

Overview:
- Initiator side of the ap_ctrl_hs block-level handshake that the dataflow/module-status monitors observe.
- Drives ap_start and ap_continue into an HLS top, counts start and done handshakes, and measures run length.
- Raises the `finish` flag that the monitor sample manager waits on.
- Sits in the simulation top beside the AESL instance and replaces ad-hoc testbench start logic with a synthesizable sequencer.

Parameters:
- NUM_TRANS, 16: transactions launched per run (>=1).
- CNT_W, 32: width of all counters.
- TIMEOUT, 1024: max cycles in DRAIN without an accepted ap_done before abort.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level request to start a run.
- hold_continue  in  1  back-pressure; when 1, ap_continue is forced low.
- ap_start  out  1  block start request to the DUT.
- ap_ready  in  1  DUT accepted current start.
- ap_done  in  1  DUT result valid.
- ap_idle  in  1  DUT idle; used only for the FINISH entry condition.
- ap_continue  out  1  downstream accepts done.
- start_count  out  CNT_W  accepted starts this run.
- done_count  out  CNT_W  accepted dones this run.
- run_cycles  out  CNT_W  cycles from leaving IDLE to entering FINISH.
- finish  out  1  run complete, held high until released.
- timeout_err  out  1  sticky, set when a run aborts on timeout.
- protocol_err  out  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Reset (async, active-high): state=IDLE. ap_start, ap_continue, finish, timeout_err and protocol_err are 0. All counters are 0.
- State machine: IDLE, LAUNCH, DRAIN, FINISH.
- IDLE:
  - enable=1 -> LAUNCH next cycle.
  - On that transition, clear start_count, done_count, run_cycles and timeout_err.
- LAUNCH:
  - ap_start=1, decoded from the state register with no combinational path from inputs.
  - A start handshake is ap_start&&ap_ready on a posedge; each one increments start_count.
  - The handshake that makes start_count==NUM_TRANS moves the FSM to DRAIN, so ap_start is low the following cycle.
  - Starts are back-to-back: ap_ready held high gives one start per cycle.
- DRAIN:
  - ap_start=0.
  - Idle timer counts cycles since the last accepted done, and resets on every accepted done.
  - Moves to FINISH when done_count==NUM_TRANS and ap_idle=1.
  - Also moves to FINISH when the idle timer reaches TIMEOUT, setting timeout_err=1.
- FINISH:
  - finish=1 and ap_start=0; run_cycles stops counting.
  - Stays in FINISH until enable=0, then returns to IDLE with finish=0.
  - Counters hold their values until the next run starts.
- ap_continue = (state!=IDLE) && !hold_continue, combinational.
- A done handshake is ap_done&&ap_continue; each one increments done_count.
  - A done with ap_continue=0 is not counted; the DUT must hold it.
- Done handshakes are counted in LAUNCH as well as DRAIN (pipelined DUT).
- A start and a done in the same cycle both count.
- A done on the same edge as the last start counts, and the FSM still goes to DRAIN.
- run_cycles increments every cycle in LAUNCH and DRAIN.
- Counters saturate at all-ones and do not wrap.
- enable dropping during LAUNCH or DRAIN is ignored; the run completes.
- reset mid-run: immediate return to reset values, with ap_start low asynchronously.

Optional Feature:
- Macro: AP_CTRL_PROTOCOL_CHECK_EN.
- Defined: protocol_err is set and held (sticky until reset or a new run) on any of:
  - an accepted done while done_count==start_count (done with nothing outstanding);
  - ap_ready=1 while ap_start=0;
  - ap_done=1 while in IDLE.
  - Each violation also prints a $error with the cycle number, inside a simulation-only block.
- Not defined: protocol_err is tied to 0 and no check logic is generated. All other behaviour is identical.

Test Plan:
- NUM_TRANS=4, DUT with ap_ready=1 always and ap_done 3 cycles after each start, hold_continue=0 -> ap_start high exactly 4 cycles; start_count=4, done_count=4; finish=1 after ap_idle; timeout_err=0.
- ap_ready low for 5 cycles after the first assertion of ap_start -> ap_start stays high through the stall; start_count increments only on the ready cycle; no start is lost or duplicated.
- hold_continue=1 for 10 cycles while the DUT holds ap_done -> done_count unchanged during the hold; increments by 1 on the first cycle after release.
- TIMEOUT=20, DUT never asserts ap_done -> FINISH entered 20 cycles after DRAIN entry; timeout_err=1; finish=1; done_count=0.
- Reset asserted mid-LAUNCH at start_count=2 -> ap_start=0 in the same cycle; all counters 0. Re-enabling the run gives a clean run of NUM_TRANS.
- With AP_CTRL_PROTOCOL_CHECK_EN, inject ap_done with no outstanding start -> protocol_err=1 and sticky. Without the macro, protocol_err stays 0.
